// File: rtl/axi_req_arbiter.sv
// Arbitrates a write burst path and a read header path onto one TLP builder.
// Moore FSM: a granted transfer runs to completion; ties alternate on last_srv.
module axi_req_arbiter #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 ARST,
  input  logic                 wr_req,
  input  logic [LEN_WIDTH-1:0] wr_len,
  input  logic                 rd_req,
  input  logic                 tl_ready,
  input  logic                 fc_p_ok,
  input  logic                 fc_np_ok,
  output logic                 axi_req_wr_grant,
  output logic                 axi_req_rd_grant,
  output logic                 req_sel,
  output logic                 arb_busy
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    WR_HDR   = 2'd1,
    WR_DATA  = 2'd2,
    RD_HDR   = 2'd3
  } arb_state_t;

  arb_state_t           state, state_n;
  logic [LEN_WIDTH-1:0] beat_cnt, beat_cnt_n;
  logic                 last_srv, last_srv_n;
  logic                 wr_elig, rd_elig;

  // Credits and builder readiness only matter at arbitration time.
  assign wr_elig = wr_req & fc_p_ok & tl_ready;
  assign rd_elig = rd_req & fc_np_ok & tl_ready;

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    last_srv_n = last_srv;
    case (state)
      ARB_IDLE: begin
        if (wr_elig && (!rd_elig || !last_srv)) begin
          state_n    = WR_HDR;
          beat_cnt_n = wr_len;
          last_srv_n = 1'b1;
        end else if (rd_elig) begin
          state_n    = RD_HDR;
          last_srv_n = 1'b0;
        end
      end
      WR_HDR: begin
        if (tl_ready) begin
          state_n = (beat_cnt == '0) ? ARB_IDLE : WR_DATA;
        end
      end
      WR_DATA: begin
        // beat_cnt counts remaining data beats after the header beat; exits at 1 so it never wraps.
        if (tl_ready) begin
          beat_cnt_n = beat_cnt - LEN_WIDTH'(1);
          if (beat_cnt == LEN_WIDTH'(1)) begin
            state_n = ARB_IDLE;
          end
        end
      end
      RD_HDR: begin
        if (tl_ready) begin
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      state            <= ARB_IDLE;
      beat_cnt         <= '0;
      last_srv         <= 1'b0;
      axi_req_wr_grant <= 1'b0;
      axi_req_rd_grant <= 1'b0;
      req_sel          <= 1'b0;
      arb_busy         <= 1'b0;
    end else begin
      state            <= state_n;
      beat_cnt         <= beat_cnt_n;
      last_srv         <= last_srv_n;
      // Outputs are registered copies of the decode of the next state.
      axi_req_wr_grant <= (state_n == WR_HDR) || (state_n == WR_DATA);
      axi_req_rd_grant <= (state_n == RD_HDR);
      req_sel          <= (state_n == WR_HDR) || (state_n == WR_DATA) ||
                          ((state_n == ARB_IDLE) && last_srv_n);
      arb_busy         <= (state_n != ARB_IDLE);
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: a table of single-cycle vectors plus
// hand-written multi-cycle sequences for bursts, stalls, alternation and reset.
module tb_axi_req_arbiter;

  logic       clk = 1'b0;
  logic       arst;
  logic       wr_req;
  logic [7:0] wr_len;
  logic       rd_req;
  logic       tl_ready;
  logic       fc_p_ok;
  logic       fc_np_ok;
  logic       wr_grant;
  logic       rd_grant;
  logic       req_sel;
  logic       arb_busy;
  logic [3:0] outs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       wr_req;
    logic [7:0] wr_len;
    logic       rd_req;
    logic       tl_ready;
    logic       fc_p_ok;
    logic       fc_np_ok;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[19];
  int   pat21[6] = '{1, 1, 0, 0, 1, 1};

  axi_req_arbiter #(.LEN_WIDTH(8)) dut (
    .CLK              (clk),
    .ARST             (arst),
    .wr_req           (wr_req),
    .wr_len           (wr_len),
    .rd_req           (rd_req),
    .tl_ready         (tl_ready),
    .fc_p_ok          (fc_p_ok),
    .fc_np_ok         (fc_np_ok),
    .axi_req_wr_grant (wr_grant),
    .axi_req_rd_grant (rd_grant),
    .req_sel          (req_sel),
    .arb_busy         (arb_busy)
  );

  assign outs = {wr_grant, rd_grant, req_sel, arb_busy};

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {wr,rd,sel,busy}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; grants must be exclusive.
  task automatic tick();
    @(posedge clk);
    #1;
    total++;
    if (wr_grant && rd_grant) begin
      bad++;
      $display("FAIL excl: got wr=%b rd=%b expected not both 1", wr_grant, rd_grant);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] len, input logic r,
                       input logic tl, input logic fp, input logic fn);
    wr_req   = w;
    wr_len   = len;
    rd_req   = r;
    tl_ready = tl;
    fc_p_ok  = fp;
    fc_np_ok = fn;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    arst = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] len, input logic r,
                              input logic tl, input logic fp, input logic fn,
                              input logic [3:0] exp);
    vec_t v;
    v.wr_req   = w;
    v.wr_len   = len;
    v.rd_req   = r;
    v.tl_ready = tl;
    v.fc_p_ok  = fp;
    v.fc_np_ok = fn;
    v.exp      = exp;
    return v;
  endfunction

  initial begin
    int gcnt;
    int beats;
    int rd_seen;
    logic [1:0] exp22[8];

    // expected outputs are {wr_grant, rd_grant, req_sel, arb_busy}
    vecs[0]  = mk(0, 8'd0, 0, 1, 1, 1, 4'b0000);
    vecs[1]  = mk(1, 8'd0, 0, 1, 0, 1, 4'b0000);
    vecs[2]  = mk(1, 8'd0, 0, 0, 1, 1, 4'b0000);
    vecs[3]  = mk(1, 8'd0, 0, 1, 1, 1, 4'b1011);
    vecs[4]  = mk(0, 8'd0, 0, 1, 1, 1, 4'b0010);
    vecs[5]  = mk(0, 8'd0, 1, 1, 1, 1, 4'b0101);
    vecs[6]  = mk(0, 8'd0, 0, 0, 1, 1, 4'b0101);
    vecs[7]  = mk(0, 8'd0, 0, 1, 1, 1, 4'b0000);
    vecs[8]  = mk(1, 8'd0, 1, 1, 1, 1, 4'b1011);
    vecs[9]  = mk(1, 8'd0, 1, 1, 1, 1, 4'b0010);
    vecs[10] = mk(1, 8'd0, 1, 1, 1, 1, 4'b0101);
    vecs[11] = mk(1, 8'd0, 1, 1, 1, 1, 4'b0000);
    vecs[12] = mk(0, 8'd0, 1, 1, 1, 0, 4'b0000);
    vecs[13] = mk(1, 8'd2, 1, 1, 1, 1, 4'b1011);
    vecs[14] = mk(0, 8'd0, 1, 1, 1, 1, 4'b1011);
    vecs[15] = mk(0, 8'd0, 1, 1, 1, 1, 4'b1011);
    vecs[16] = mk(0, 8'd0, 1, 1, 1, 1, 4'b0010);
    vecs[17] = mk(0, 8'd0, 1, 1, 1, 1, 4'b0101);
    vecs[18] = mk(0, 8'd0, 0, 1, 1, 1, 4'b0000);

    do_reset();
    chk("reset", outs, 4'b0000);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].wr_req, vecs[i].wr_len, vecs[i].rd_req,
            vecs[i].tl_ready, vecs[i].fc_p_ok, vecs[i].fc_np_ok);
      tick();
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // single-beat write: grant one cycle after request, for exactly one cycle
    do_reset();
    drive(1, 8'd0, 0, 1, 1, 0);
    tick();
    chk("w0_latency", outs, 4'b1011);
    wr_req = 1'b0;
    gcnt = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_grant) gcnt++;
    end
    chk_int("w0_grant_cycles", gcnt, 1);
    chk("w0_idle", outs, 4'b0010);

    // wr_len=3 with a two-cycle stall; a pending read must wait
    drive(1, 8'd3, 0, 1, 1, 1);
    tick();
    wr_req = 1'b0;
    wr_len = 8'd0;
    rd_req = 1'b1;
    gcnt = 0;
    beats = 0;
    rd_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tl_ready = (k < 6) ? pat21[k][0] : 1'b1;
      if (!wr_grant) break;
      gcnt++;
      if (tl_ready) beats++;
      if (rd_grant) rd_seen++;
      tick();
    end
    chk_int("w3_grant_cycles", gcnt, 6);
    chk_int("w3_beats", beats, 4);
    chk_int("w3_rd_during_wr", rd_seen, 0);
    chk("w3_idle_gap", outs, 4'b0010);
    tick();
    chk("w3_rd_after", outs, 4'b0101);
    rd_req = 1'b0;
    tick();
    chk("w3_rd_done", outs, 4'b0000);

    // both requesters held: W, idle, R, idle, ...
    exp22 = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    drive(1, 8'd0, 1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("alt%0d", i), {2'b00, wr_grant, rd_grant}, {2'b00, exp22[i]});
    end
    drive(0, 8'd0, 0, 1, 1, 1);
    tick();

    // read blocked by missing non-posted credits
    drive(0, 8'd0, 1, 1, 1, 0);
    rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_grant) rd_seen++;
    end
    chk_int("np_blocked", rd_seen, 0);
    fc_np_ok = 1'b1;
    tick();
    chk("np_return", outs, 4'b0101);
    rd_req = 1'b0;
    tick();

    // reset in the middle of an 8-beat burst
    drive(1, 8'd7, 0, 1, 1, 1);
    tick();
    wr_req = 1'b0;
    tick();
    chk("abort_pre", outs, 4'b1011);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("abort_reset", outs, 4'b0000);
    tick();
    chk("abort_stays_idle", outs, 4'b0000);
    drive(1, 8'd0, 1, 1, 1, 1);
    tick();
    chk("abort_write_first", outs, 4'b1011);
    drive(0, 8'd0, 0, 1, 1, 1);
    tick();

    // maximum burst length, wr_len changes after capture are ignored
    drive(1, 8'hFF, 0, 1, 1, 1);
    tick();
    wr_req = 1'b0;
    wr_len = 8'd0;
    gcnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (!wr_grant) break;
      gcnt++;
      tick();
    end
    chk_int("max_burst_beats", gcnt, 256);
    chk("max_burst_idle", outs, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_req_arbiter.md
AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 8, meaning width of the write burst length field (AWLEN, beats minus 1).
REQ-002 SHALL have ports:
- CLK  in  1  single clock; all logic on its rising edge.
- ARST  in  1  reset; synchronous and active-high.
- wr_req  in  1  write pop FSM has an AW header and first W beat ready.
- wr_len  in  LEN_WIDTH  AWLEN of the pending write; valid while wr_req=1.
- rd_req  in  1  read pop FSM has an AR header ready.
- tl_ready  in  1  TLP builder accepts a beat this cycle.
- fc_p_ok  in  1  posted flow-control credits available.
- fc_np_ok  in  1  non-posted flow-control credits available.
- axi_req_wr_grant  out  1  write path owns the TLP builder this cycle.
- axi_req_rd_grant  out  1  read path owns the TLP builder this cycle.
- req_sel  out  1  data mux select: 1=write path, 0=read path.
- arb_busy  out  1  a transfer is in progress (state != ARB_IDLE).

Function
REQ-003 SHALL implement FSM states ARB_IDLE, WR_HDR, WR_DATA, RD_HDR; all outputs are decoded from registered state and registered counters only (Moore).
REQ-004 SHALL treat a write as eligible when wr_req & fc_p_ok & tl_ready, and a read as eligible when rd_req & fc_np_ok & tl_ready, both sampled in ARB_IDLE.
REQ-005 In ARB_IDLE with only one eligible requester, SHALL go to WR_HDR (write) or RD_HDR (read) next cycle.
REQ-006 In ARB_IDLE with both eligible, SHALL grant the requester opposite to last_srv, a 1-bit register (1=write last served, 0=read) updated on entry to WR_HDR or RD_HDR.
REQ-007 With nothing eligible, SHALL remain in ARB_IDLE with both grants 0.
REQ-008 On ARB_IDLE->WR_HDR, SHALL capture wr_len into beat_cnt (LEN_WIDTH bits); later changes on wr_len SHALL be ignored until the burst ends.
REQ-009 WR_HDR: axi_req_wr_grant=1, req_sel=1.
- tl_ready=0: stay in WR_HDR.
- tl_ready=1 and beat_cnt=0: go to ARB_IDLE.
- tl_ready=1 and beat_cnt!=0: go to WR_DATA.
REQ-010 WR_DATA: axi_req_wr_grant=1, req_sel=1.
- Each cycle with tl_ready=1, beat_cnt decrements by 1.
- tl_ready=1 and beat_cnt=1: go to ARB_IDLE.
- tl_ready=0: hold state and beat_cnt.
REQ-011 A write burst SHALL keep the grant for exactly wr_len+1 accepted beats; read requests arriving mid-burst SHALL wait and SHALL NOT preempt.
REQ-012 RD_HDR: axi_req_rd_grant=1, req_sel=0.
- tl_ready=0: stay.
- tl_ready=1: go to ARB_IDLE.
REQ-013 Grant latency from an eligible request in ARB_IDLE SHALL be exactly 1 cycle; after a transfer completes, the arbiter SHALL spend at least 1 cycle in ARB_IDLE.
REQ-014 axi_req_wr_grant and axi_req_rd_grant SHALL never be 1 in the same cycle.
REQ-015 A started grant SHALL NOT be retracted if wr_req/rd_req or fc_*_ok deassert mid-transfer; credits are checked only at arbitration.
REQ-016 beat_cnt SHALL never wrap. wr_len = all-ones SHALL produce 2^LEN_WIDTH beats.
REQ-017 In ARB_IDLE, req_sel SHALL equal last_srv.

Reset
REQ-018 When ARST=1 at a rising CLK edge, SHALL set state=ARB_IDLE, beat_cnt=0, last_srv=0. Outputs then read: axi_req_wr_grant=0, axi_req_rd_grant=0, req_sel=0, arb_busy=0.
REQ-019 ARST asserted mid-burst SHALL abort the transfer with no further grant cycles. The first arbitration after reset SHALL favour write (last_srv=0).

Verification
REQ-020 Reset, then wr_req=1, wr_len=0, fc_p_ok=1, tl_ready=1 -> wr_grant=1 for exactly 1 cycle starting 1 cycle later, then ARB_IDLE.
REQ-021 wr_len=3 with tl_ready deasserted for 2 cycles mid-burst -> wr_grant held for 6 cycles total, exactly 4 accepted beats, rd_grant=0 throughout even with rd_req=1.
REQ-022 wr_req and rd_req held continuously with wr_len=0 -> grants alternate W, R, W, R, each separated by one idle cycle.
REQ-023 rd_req=1 with fc_np_ok=0 for 5 cycles, then fc_np_ok=1 -> no rd_grant during the 5 cycles; rd_grant=1 one cycle after credits return.
REQ-024 ARST=1 at the 2nd data beat of wr_len=7 -> the next cycle shows all grants 0 and arb_busy=0; a subsequent simultaneous request grants write first.
REQ-025 wr_len=8'hFF -> exactly 256 granted beats with tl_ready=1, then return to ARB_IDLE; no wrap of beat_cnt.
